// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, taken-jump redirect with a timed
// flush window, and a small return-address stack for call/ret.
module pc_sequencer #(
  parameter int unsigned           PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_PC     = '0,
  parameter int unsigned           FLUSH_CYCLES = 2,
  parameter int unsigned           STACK_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                jump_valid,
  input  logic                taken,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                call,
  input  logic                ret,
  output logic [PC_WIDTH-1:0] pc,
  output logic                fetch_valid,
  output logic                flush,
  output logic                stack_err,
  output logic [1:0]          dbg_state,
  output logic [$clog2(STACK_DEPTH+1)-1:0] dbg_depth
);

  localparam int unsigned SPW  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                flush_q, flush_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [SPW-1:0]      sp_q, sp_d;
  logic                err_q, err_d;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [PC_WIDTH-1:0] stack_d [STACK_DEPTH];

  logic [PC_WIDTH-1:0] pc_inc;
  logic [IDXW-1:0]     push_idx;
  logic [IDXW-1:0]     pop_idx;
  logic                stack_full;
  logic                stack_empty;

  assign pc_inc      = pc_q + PC_WIDTH'(1);
  assign push_idx    = IDXW'(sp_q);
  assign pop_idx     = IDXW'(sp_q - SPW'(1));
  assign stack_full  = (sp_q == SPW'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);

  // State register: every piece of sequencer state lives here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      cnt_q   <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  // Next-state logic; stall leaves every _d equal to its _q.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = flush_q;
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    err_d   = err_q;
    for (int i = 0; i < STACK_DEPTH; i++) stack_d[i] = stack_q[i];

    if (!stall) begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
        end
        RUN: begin
          if (jump_valid && taken) begin
            state_d = FLUSH;
            flush_d = 1'b1;
            cnt_d   = 3'(FLUSH_CYCLES);
            pc_d    = jump_target;
            if (call && ret) begin
              err_d = 1'b1;
            end else if (call) begin
              if (stack_full) begin
                err_d = 1'b1;
              end else begin
                stack_d[push_idx] = pc_inc;
                sp_d              = sp_q + SPW'(1);
              end
            end else if (ret) begin
              if (stack_empty) begin
                err_d = 1'b1;
                pc_d  = RESET_PC;
              end else begin
                pc_d = stack_q[pop_idx];
                sp_d = sp_q - SPW'(1);
              end
            end
          end else begin
            pc_d = pc_inc;
          end
        end
        FLUSH: begin
          // Younger instructions are squashed here, so jump_valid is ignored.
          pc_d = pc_inc;
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            flush_d = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
          flush_d = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic.
  always_comb begin
    fetch_valid = (state_q != IDLE) && !stall;
    pc          = pc_q;
    flush       = flush_q;
    stack_err   = err_q;
    dbg_state   = state_q;
    dbg_depth   = sp_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: reset, sequential fetch, jumps, flush,
// stall, return stack (nesting, overflow, underflow, illegal combo) and wrap.
module tb_pc_sequencer;

  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          jump_valid = 1'b0;
  logic          taken = 1'b0;
  logic [PW-1:0] jump_target = '0;
  logic          call = 1'b0;
  logic          ret = 1'b0;
  logic [PW-1:0] pc;
  logic          fetch_valid;
  logic          flush;
  logic          stack_err;
  logic [1:0]    dbg_state;
  logic [2:0]    dbg_depth;

  int checks = 0;
  int failures = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] cur;
  logic [PW-1:0] tgt;
  logic [PW-1:0] exp_pc;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2;

  pc_sequencer #(
    .PC_WIDTH(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(2), .STACK_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jump_valid(jump_valid),
    .taken(taken), .jump_target(jump_target), .call(call), .ret(ret),
    .pc(pc), .fetch_valid(fetch_valid), .flush(flush), .stack_err(stack_err),
    .dbg_state(dbg_state), .dbg_depth(dbg_depth)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [PW-1:0] t, input logic c, input logic r);
    jump_valid = 1'b1; taken = 1'b1; jump_target = t; call = c; ret = r;
    step();
    jump_valid = 1'b0; taken = 1'b0; call = 1'b0; ret = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    check("rst_pc", pc, 16'h0000);
    check("rst_fv", fetch_valid, 0);
    check("rst_flush", flush, 0);
    check("rst_err", stack_err, 0);
    check("rst_state", dbg_state, S_IDLE);
    rst_n = 1'b1;
    check("rel_pc", pc, 16'h0000);
    check("rel_fv", fetch_valid, 0);
    step();
    check("e1_pc", pc, 16'h0000);
    check("e1_fv", fetch_valid, 1);
    check("e1_state", dbg_state, S_RUN);
    step(); check("e2_pc", pc, 16'h0001);
    step(); check("e3_pc", pc, 16'h0002);
    step(); step(); step();
    check("pre_jump_pc", pc, 16'h0005);

    // Plain jump with a jump_valid pulse during flush
    jump(16'h0040, 1'b0, 1'b0);
    check("j_pc", pc, 16'h0040);
    check("j_flush", flush, 1);
    check("j_state", dbg_state, S_FLUSH);
    jump(16'h0099, 1'b0, 1'b0);
    check("jf_pc", pc, 16'h0041);
    check("jf_flush", flush, 1);
    step();
    check("jend_pc", pc, 16'h0042);
    check("jend_flush", flush, 0);
    check("jend_state", dbg_state, S_RUN);
    step();
    check("jrun_pc", pc, 16'h0043);
    check("jrun_flush", flush, 0);

    // Not-taken call / ret leave the stack alone
    jump(16'h001D, 1'b0, 1'b0);
    step(); step(); step();
    check("nt_pre_pc", pc, 16'h0020);
    jump_valid = 1'b1; taken = 1'b0; call = 1'b1; jump_target = 16'h0300;
    step();
    check("nt_call_pc", pc, 16'h0021);
    check("nt_call_flush", flush, 0);
    check("nt_call_depth", dbg_depth, 0);
    check("nt_call_err", stack_err, 0);
    call = 1'b0; ret = 1'b1;
    step();
    jump_valid = 1'b0; ret = 1'b0;
    check("nt_ret_pc", pc, 16'h0022);
    check("nt_ret_depth", dbg_depth, 0);

    // Call then return
    jump(16'h000D, 1'b0, 1'b0);
    step(); step(); step();
    check("call_pre_pc", pc, 16'h0010);
    jump(16'h0100, 1'b1, 1'b0);
    check("call_pc", pc, 16'h0100);
    check("call_depth", dbg_depth, 1);
    step(); step();
    check("call_run_pc", pc, 16'h0102);
    jump(16'h0000, 1'b0, 1'b1);
    check("ret_pc", pc, 16'h0011);
    check("ret_depth", dbg_depth, 0);
    check("ret_err", stack_err, 0);
    step(); step();
    check("ret_run_pc", pc, 16'h0013);

    // Nested calls up to overflow
    cur = 16'h0013;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(cur + 16'h0001);
      tgt = 16'h0200 + 16'(i * 16);
      jump(tgt, 1'b1, 1'b0);
      check("nest_pc", pc, tgt);
      check("nest_depth", dbg_depth, i + 1);
      step(); step();
      cur = tgt + 16'h0002;
    end
    check("nest_err_clear", stack_err, 0);
    jump(16'h0300, 1'b1, 1'b0);
    check("ovf_pc", pc, 16'h0300);
    check("ovf_err", stack_err, 1);
    check("ovf_depth", dbg_depth, 4);
    step(); step();

    // Five returns; last underflows to RESET_PC
    for (int i = 0; i < 5; i++) begin
      exp_pc = (exp_q.size() > 0) ? exp_q.pop_back() : 16'h0000;
      jump(16'h0AAA, 1'b0, 1'b1);
      check("unwind_pc", pc, exp_pc);
      step(); step();
    end
    check("unf_depth", dbg_depth, 0);
    check("unf_err_sticky", stack_err, 1);

    // Asynchronous reset in the middle of a flush with a live stack entry
    jump(16'h0500, 1'b1, 1'b0);
    check("mid_state", dbg_state, S_FLUSH);
    check("mid_depth", dbg_depth, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pc", pc, 16'h0000);
    check("arst_flush", flush, 0);
    check("arst_err", stack_err, 0);
    check("arst_depth", dbg_depth, 0);
    check("arst_state", dbg_state, S_IDLE);
    check("arst_fv", fetch_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    check("rerun_pc", pc, 16'h0000);
    check("rerun_state", dbg_state, S_RUN);

    // Stall in RUN blocks a taken jump
    stall = 1'b1; jump_valid = 1'b1; taken = 1'b1; jump_target = 16'h0060;
    #1 check("stall_fv", fetch_valid, 0);
    step();
    check("stall_run_pc", pc, 16'h0000);
    check("stall_run_flush", flush, 0);
    check("stall_run_state", dbg_state, S_RUN);
    stall = 1'b0; jump_valid = 1'b0; taken = 1'b0;
    step();
    check("unstall_pc", pc, 16'h0001);

    // Stall for three cycles mid-flush
    jump(16'h0050, 1'b0, 1'b0);
    check("sf_pc", pc, 16'h0050);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("sf_hold_pc", pc, 16'h0050);
      check("sf_hold_flush", flush, 1);
    end
    stall = 1'b0;
    step();
    check("sf_pc2", pc, 16'h0051);
    check("sf_flush2", flush, 1);
    step();
    check("sf_pc3", pc, 16'h0052);
    check("sf_flush3", flush, 0);

    // call and ret together
    jump(16'h0077, 1'b1, 1'b1);
    check("both_pc", pc, 16'h0077);
    check("both_err", stack_err, 1);
    check("both_depth", dbg_depth, 0);
    step(); step();

    // PC wrap
    jump(16'hFFFD, 1'b0, 1'b0);
    step(); step();
    check("wrap_pre_pc", pc, 16'hFFFF);
    check("wrap_pre_state", dbg_state, S_RUN);
    step();
    check("wrap_pc", pc, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, 16, width of program counter and jump target.
REQ-002 SHALL have parameter RESET_PC, 0, PC value loaded at reset and used on return-stack underflow.
REQ-003 SHALL have parameter FLUSH_CYCLES, 2, number of cycles flush is held after a redirect (legal 1..7).
REQ-004 SHALL have parameter STACK_DEPTH, 4, return-address stack entries.
REQ-005 SHALL have one clock and an asynchronous active-low reset, with ports clk (input, 1, rising-edge clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-006 SHALL have port stall  input  1  freezes all state when high.
REQ-007 SHALL have port jump_valid  input  1  a jump/branch instruction is resolving this cycle.
REQ-008 SHALL have port taken  input  1  branch decision from the jump-condition stage, sampled only with jump_valid.
REQ-009 SHALL have port jump_target  input  PC_WIDTH  destination of a taken non-return jump.
REQ-010 SHALL have ports call and ret  input  1 each  qualify a taken jump as subroutine call or return.
REQ-011 SHALL have port pc  output  PC_WIDTH  current fetch address (registered).
REQ-012 SHALL have port fetch_valid  output  1  pc is a valid fetch this cycle.
REQ-013 SHALL have port flush  output  1  squash younger in-flight instructions (registered).
REQ-014 SHALL have port stack_err  output  1  sticky return-stack overflow/underflow/illegal-combination flag.

Function
REQ-015 SHALL implement states IDLE, RUN and FLUSH; IDLE is entered only by reset.
REQ-016 SHALL move IDLE->RUN on the first clock edge after rst_n deasserts, holding pc at RESET_PC.
REQ-017 SHALL drive fetch_valid = (state != IDLE) & ~stall, combinationally.
REQ-018 SHALL, while stall=1, hold pc, state, flush counter, stack and flush output unchanged, regardless of jump_valid.
REQ-019 SHALL, in RUN with stall=0 and no taken jump (jump_valid=0 or taken=0), set pc <= pc+1 modulo 2^PC_WIDTH (0xFFFF wraps to 0x0000).
REQ-020 SHALL, in RUN with stall=0, jump_valid=1, taken=1, load the redirect target into pc, enter FLUSH, assert flush for exactly FLUSH_CYCLES non-stalled cycles starting the next cycle.
REQ-021 SHALL use target = jump_target for a plain jump; for call=1, ret=0 push pc+1 and use jump_target; for ret=1, call=0 pop and use the popped value.
REQ-022 SHALL perform no stack change when taken=0 or jump_valid=0, whatever call/ret are.
REQ-023 SHALL on call with stack full skip the push, set stack_err, and still redirect to jump_target.
REQ-024 SHALL on ret with stack empty set stack_err and redirect to RESET_PC.
REQ-025 SHALL on call=1 and ret=1 together set stack_err, leave the stack unchanged and redirect to jump_target.
REQ-026 SHALL in FLUSH increment pc each non-stalled cycle and ignore jump_valid (those instructions are squashed).
REQ-027 SHALL return FLUSH->RUN when the flush count expires; flush deasserts that same edge.
REQ-028 SHALL keep stack_err set until reset.

Reset
REQ-029 SHALL on rst_n=0, asynchronously: state=IDLE, pc=RESET_PC, flush=0, stack_err=0, stack empty, flush counter=0; fetch_valid therefore 0.
REQ-030 SHALL abandon any in-progress FLUSH and discard stack contents on reset mid-operation.

Verification
REQ-031 SHALL cover: release reset, stall=0, no jumps -> pc 0x0000,0x0000,0x0001,0x0002; fetch_valid 0 then 1 from the second edge.
REQ-032 SHALL cover: at pc=0x0005 jump_valid=1, taken=1, target=0x0040 -> pc 0x0040,0x0041,0x0042; flush=1 for 2 cycles; jump_valid pulse during flush ignored; then pc 0x0043 with flush=0.
REQ-033 SHALL cover: jump_valid=1, taken=0, call=1 at pc=0x0020 -> pc=0x0021, flush=0, stack unchanged, stack_err=0.
REQ-034 SHALL cover: call at pc=0x0010 target 0x0100, after flush ret taken -> pc=0x0011, stack empty, stack_err=0.
REQ-035 SHALL cover: five nested taken calls -> fifth sets stack_err, depth 4; five rets -> fifth redirects to 0x0000.
REQ-036 SHALL cover: stall=1 for 3 cycles mid-FLUSH -> pc and flush frozen, flush still totals 2 unstalled cycles; separately pc=0xFFFF advances to 0x0000.
